bcd_display_scanner: RTL and testbench

//  Drives a 3-digit multiplexed common-anode 7-segment display from the 12-bit BCD bus

---
 rtl/display_pkg.sv | 36 +++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/bcd_display_scanner.sv | 133 +++++++++++++
 tb/tb_bcd_display_scanner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
// Segment codes are active-low {g,f,e,d,c,b,a} for a common-anode display.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // Active-low one-cold anode pattern for a digit index.
  function automatic logic [2:0] anode_sel(input digit_idx_t d);
    logic [2:0] an;
    case (d)
      2'd0:    an = 3'b110;
      2'd1:    an = 3'b101;
      default: an = 3'b011;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-BCD nibbles render as a dash so bad data is visible rather than hidden.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_DASH;
    case (i_nibble)
      4'd0: o_seg_n = SEG_0;
      4'd1: o_seg_n = SEG_1;
      4'd2: o_seg_n = SEG_2;
      4'd3: o_seg_n = SEG_3;
      4'd4: o_seg_n = SEG_4;
      4'd5: o_seg_n = SEG_5;
      4'd6: o_seg_n = SEG_6;
      4'd7: o_seg_n = SEG_7;
      4'd8: o_seg_n = SEG_8;
      4'd9: o_seg_n = SEG_9;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// 3-digit multiplexed 7-segment scanner: frame-synchronous snapshot of the BCD bus,
// per-slot anode guard time, and optional leading-zero blanking.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        lzb,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_dig;
  logic [0:0]       r_state;
  logic [11:0]      r_disp;
  logic [11:0]      r_pend;
  logic             r_pend_v;
  logic [6:0]       r_seg_n;
  logic [2:0]       r_an_n;
  logic             r_frame_done;

  logic             w_slot_end;
  logic             w_wrap;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_n;
  logic             w_blank2;
  logic             w_blank1;
  logic             w_cur_blank;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_wrap     = w_slot_end && (r_dig == LAST_DIGIT);

  // State tracks the counter: SHOW is entered as the counter reaches GUARD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dig   <= '0;
      r_state <= ST_GUARD;
    end else if (w_slot_end) begin
      r_cnt   <= '0;
      r_state <= ST_GUARD;
      r_dig   <= w_wrap ? '0 : digit_idx_t'(r_dig + 2'd1);
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == GUARD_LAST)
        r_state <= ST_SHOW;
    end
  end

  // A load coinciding with the wrap bypasses pending and lands in this frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_disp   <= '0;
    end else begin
      if (load)
        r_pend <= bcd_in;
      if (w_wrap) begin
        r_pend_v <= 1'b0;
        if (load)
          r_disp <= bcd_in;
        else if (r_pend_v)
          r_disp <= r_pend;
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nibble = r_disp[11:8];
    case (r_dig)
      2'd0:    w_nibble = r_disp[3:0];
      2'd1:    w_nibble = r_disp[7:4];
      default: w_nibble = r_disp[11:8];
    endcase
  end

  // Only a literal zero blanks, so invalid nibbles always show as a dash.
  assign w_blank2 = lzb && (r_disp[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_disp[7:4] == 4'd0);

  always_comb begin
    w_cur_blank = 1'b0;
    case (r_dig)
      2'd1:    w_cur_blank = w_blank1;
      2'd2:    w_cur_blank = w_blank2;
      default: w_cur_blank = 1'b0;
    endcase
  end

  bcd_to_7seg u_dec (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_n      <= SEG_BLANK;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if ((r_state == ST_SHOW) && !w_cur_blank) begin
        r_seg_n <= w_seg_n;
        r_an_n  <= anode_sel(r_dig);
      end else begin
        r_seg_n <= SEG_BLANK;
        r_an_n  <= '1;
      end
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with PRESCALE=8, GUARD=2 (24-cycle frame).
// t counts edges since the last reset; frame f, digit d shows mid-slot at t=24f+8d+5.
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic        lzb;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  bcd_display_scanner #(.PRESCALE(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .lzb        (lzb),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int tt);
    while (t < tt) tick();
  endtask

  function automatic int ts(input int f, input int d);
    return 24 * f + 8 * d + 5;
  endfunction

  task automatic do_load(input logic [11:0] v);
    bcd_in = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [6:0] seg_e, input logic [2:0] an_e);
    total++;
    assert (seg_n === seg_e) else begin
      bad++;
      $error("FAIL %s seg_n got=%h exp=%h (t=%0d)", tag, seg_n, seg_e, t);
    end
    total++;
    assert (an_n === an_e) else begin
      bad++;
      $error("FAIL %s an_n got=%b exp=%b (t=%0d)", tag, an_n, an_e, t);
    end
  endtask

  task automatic chk_fd(input string tag, input logic exp);
    total++;
    assert (frame_done === exp) else begin
      bad++;
      $error("FAIL %s frame_done got=%b exp=%b (t=%0d)", tag, frame_done, exp, t);
    end
  endtask

  initial begin
    // 1: reset with load asserted, then first slot timing
    rst_n = 1'b0; load = 1'b1; bcd_in = 12'h999; lzb = 1'b0;
    tick(); tick(); tick();
    chk("rst_out", 7'h7F, 3'b111);
    chk_fd("rst_fd", 1'b0);
    rst_n = 1'b1; load = 1'b0; t = 0;
    goto(2);  chk("guard_d0", 7'h7F, 3'b111);
    goto(3);  chk("show_d0_first", 7'h40, 3'b110);

    // 2: guard between slots, load 123 mid-frame
    goto(9);  chk("guard_d1_a", 7'h7F, 3'b111);
    goto(10); chk("guard_d1_b", 7'h7F, 3'b111);
    goto(11); chk("show_d1_first", 7'h40, 3'b101);
    goto(13); do_load(12'h123);
    goto(ts(0, 2)); chk("f0_d2_still0", 7'h40, 3'b011);
    goto(23); chk_fd("fd_before", 1'b0);
    goto(24); chk_fd("fd_at24", 1'b1);
    goto(25); chk_fd("fd_after", 1'b0);
    goto(ts(1, 0)); chk("f1_d0_3", 7'h30, 3'b110);
    goto(ts(1, 1)); chk("f1_d1_2", 7'h24, 3'b101);
    goto(ts(1, 2)); chk("f1_d2_1", 7'h79, 3'b011);
    goto(48); chk_fd("fd_at48", 1'b1);

    // 3: leading-zero blanking
    lzb = 1'b1;
    do_load(12'h005);
    goto(ts(3, 0)); chk("lzb005_d0", 7'h12, 3'b110);
    goto(ts(3, 1)); chk("lzb005_d1", 7'h7F, 3'b111);
    goto(ts(3, 2)); chk("lzb005_d2", 7'h7F, 3'b111);
    goto(94); do_load(12'h000);
    goto(ts(4, 0)); chk("lzb000_d0", 7'h40, 3'b110);
    goto(ts(4, 1)); chk("lzb000_d1", 7'h7F, 3'b111);
    goto(ts(4, 2)); chk("lzb000_d2", 7'h7F, 3'b111);
    goto(118); do_load(12'h105);
    goto(ts(5, 0)); chk("lzb105_d0", 7'h12, 3'b110);
    goto(ts(5, 1)); chk("lzb105_d1", 7'h40, 3'b101);
    goto(ts(5, 2)); chk("lzb105_d2", 7'h79, 3'b011);

    // 4: invalid nibbles show a dash and are never blanked
    goto(142); do_load(12'hA0F);
    goto(ts(6, 0)); chk("inv_d0", 7'h3F, 3'b110);
    goto(ts(6, 1)); chk("inv_d1", 7'h40, 3'b101);
    goto(ts(6, 2)); chk("inv_d2", 7'h3F, 3'b011);

    // 5: latest load wins; wrap-cycle load bypasses pending
    goto(166); do_load(12'h111); do_load(12'h222);
    goto(ts(7, 0)); chk("latest_d0", 7'h24, 3'b110);
    goto(ts(7, 2)); chk("latest_d2", 7'h24, 3'b011);
    goto(185); do_load(12'h111);
    goto(191); do_load(12'h333);
    chk_fd("fd_at192", 1'b1);
    goto(ts(8, 0)); chk("bypass_d0", 7'h30, 3'b110);
    goto(ts(8, 1)); chk("bypass_d1", 7'h30, 3'b101);

    // 6: reset mid-SHOW with a pending load
    do_load(12'h777);
    rst_n = 1'b0;
    tick();
    chk("midrst_out", 7'h7F, 3'b111);
    chk_fd("midrst_fd", 1'b0);
    rst_n = 1'b1; t = 0;
    goto(3);  chk("rst2_d0_first", 7'h40, 3'b110);
    goto(ts(0, 1)); chk("rst2_d1_blank", 7'h7F, 3'b111);
    goto(24); chk_fd("rst2_fd24", 1'b1);
    goto(ts(1, 0)); chk("rst2_no_pend", 7'h40, 3'b110);
    goto(ts(1, 2)); chk("rst2_d2_blank", 7'h7F, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
